seq_engine: RTL and testbench
=============================

SEQ_ENGINE -- requirements
Module: seq_engine

Interface
REQ-001 SHALL have parameter MAX_ROUNDS, default 32, meaning the sequence storage depth (entries); must be ≤ 63.
REQ-002 SHALL have parameter BASE_TICKS, default 25_000_000, meaning the pulse on/off duration in clk cycles at speed 0.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 cmd_clear  input  1  empty the sequence and abort any activity.
REQ-006 cmd_add  input  1  append rng_color to the sequence.
REQ-007 rng_color  input  2  color to append.
REQ-008 cmd_play  input  1  replay the whole stored sequence on the LED outputs.
REQ-009 speed  input  2  playback speed level, sampled at cmd_play.
REQ-010 cmd_check  input  1  compare press_color against the next expected entry.
REQ-011 press_color  input  2  color pressed by the player.
REQ-012 led_on  output  1  playback LED active.
REQ-013 led_color  output  2  color being shown.
REQ-014 play_busy  output  1  playback in progress.
REQ-015 play_done  output  1  one-cycle pulse when playback ends.
REQ-016 check_ok  output  1  one-cycle pulse on correct press.
REQ-017 check_fail  output  1  one-cycle pulse on wrong press.
REQ-018 round_done  output  1  one-cycle pulse, coincident with check_ok, when the last entry is matched.
REQ-019 current_round  output  6  number of stored entries.
REQ-020 seq_full  output  1  current_round == MAX_ROUNDS.

Function
REQ-021 State machine SHALL have the states IDLE, SHOW_ON and SHOW_OFF.
REQ-022 At most one command SHALL be accepted per cycle, with priority clear > add > play > check; lower-priority commands asserted in the same cycle SHALL be dropped.
REQ-023 cmd_clear SHALL, in any state, set current_round=0, reset the play and check indices, drive led_on low and enter IDLE on the next edge without pulsing play_done.
REQ-024 cmd_add in IDLE with seq_full low SHALL write rng_color at index current_round and increment current_round; when seq_full is high, or in a non-IDLE state, cmd_add SHALL be ignored.
REQ-025 cmd_play in IDLE SHALL latch on_ticks = BASE_TICKS >> speed and reset the play index to 0.
REQ-026 After cmd_play at edge t with current_round>0, the block SHALL enter SHOW_ON at t+1.
REQ-027 In SHOW_ON, led_on=1 and led_color=mem[play_idx] SHALL hold for exactly on_ticks cycles.
REQ-028 SHOW_OFF SHALL then hold led_on=0 for exactly on_ticks cycles, after which play_idx increments.
REQ-029 After SHOW_OFF of the last entry, the block SHALL return to IDLE and pulse play_done for exactly one cycle.
REQ-030 cmd_play with current_round==0 SHALL pulse play_done at t+1 and leave led_on low.
REQ-031 play_busy SHALL be high exactly while in SHOW_ON or SHOW_OFF.
REQ-032 cmd_play and cmd_check SHALL be ignored while play_busy is high.
REQ-033 The check index SHALL reset to 0 on every accepted cmd_play.
REQ-034 cmd_check in IDLE with current_round>0 SHALL produce exactly one result pulse at t+1.
REQ-035 If press_color==mem[chk_idx], the block SHALL pulse check_ok and increment chk_idx.
REQ-036 If that match is at chk_idx==current_round-1, the block SHALL also pulse round_done and reset chk_idx to 0.
REQ-037 On a mismatch, the block SHALL pulse check_fail and reset chk_idx to 0.
REQ-038 cmd_check with current_round==0 SHALL be ignored.
REQ-039 led_color SHALL be 0 whenever led_on is low.
REQ-040 The sequence storage SHALL not be reset, and its contents at indices ≥ current_round SHALL be don't-care.

Reset
REQ-041 On reset, the block SHALL enter IDLE with current_round=0, indices=0, and all outputs low; seq_full SHALL be 0.
REQ-042 Reset asserted mid-playback SHALL drop led_on within the same cycle (asynchronous) and SHALL not pulse play_done.

Structure
REQ-043 Package simon_pkg SHALL hold the color_t typedef (2 bits: GREEN=0, RED=1, YELLOW=2, BLUE=3), the engine state enum and the MAX_ROUNDS default.
REQ-044 One sub-module, tick_timer, SHALL be instantiated: a loadable down-counter with a done flag.

Verification (BASE_TICKS=8)
REQ-045 Reset; add 2, 0, 3; play at speed 0 -> led_on high 8 cycles with color 2, low 8, then color 0, then color 3; play_done pulses once, 48 cycles after t+1.
REQ-046 Store 1, 2; play at speed 2 -> 2-cycle on/off phases; checks of 1 then 2 -> check_ok, check_ok+round_done; check of 1 -> check_ok again (index wrapped).
REQ-047 Store 1, 2; check 3 -> check_fail, next check of 1 -> check_ok (index reset).
REQ-048 With MAX_ROUNDS=4: add 5 times -> current_round=4, seq_full=1, fifth write ignored; cmd_add and cmd_play in the same cycle -> only add accepted.
REQ-049 cmd_clear mid-SHOW_ON -> led_on=0 and current_round=0 next cycle, no play_done; play at empty -> play_done at t+1.
REQ-050 Assert reset mid-SHOW_OFF -> all outputs 0 immediately; cmd_check during playback -> no result pulse.

Source files
------------

// File: rtl/simon_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simon_pkg : shared color/state types and default depth for seq_engine |
// | Revision  : 1.0                                                      |
// +--------------------------------------------------------------------+
package simon_pkg;

  localparam int MAX_ROUNDS_DEFAULT = 32;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    RED    = 2'd1,
    YELLOW = 2'd2,
    BLUE   = 2'd3
  } color_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHOW_ON  = 2'd1,
    SHOW_OFF = 2'd2
  } engine_state_t;

endpackage
`default_nettype wire

// File: rtl/tick_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_timer : loadable down-counter, done while the count is zero   |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module tick_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/seq_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_engine : stores a color sequence, replays it on an LED, checks  |
// |              player presses against it                             |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module seq_engine
  import simon_pkg::*;
#(
  parameter int MAX_ROUNDS = MAX_ROUNDS_DEFAULT,
  parameter int BASE_TICKS = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_clear,
  input  logic       cmd_add,
  input  logic [1:0] rng_color,
  input  logic       cmd_play,
  input  logic [1:0] speed,
  input  logic       cmd_check,
  input  logic [1:0] press_color,
  output logic       led_on,
  output logic [1:0] led_color,
  output logic       play_busy,
  output logic       play_done,
  output logic       check_ok,
  output logic       check_fail,
  output logic       round_done,
  output logic [5:0] current_round,
  output logic       seq_full
);

  localparam int             c_AW  = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;
  localparam int             c_TW  = $clog2(BASE_TICKS + 1);
  localparam logic [5:0]     c_MAX = 6'(MAX_ROUNDS);
  localparam logic [c_TW-1:0] c_ONE = c_TW'(1);

  engine_state_t   r_state, w_state;
  logic [5:0]      r_round, w_round;
  logic [5:0]      r_play_idx, w_play_idx;
  logic [5:0]      r_chk_idx, w_chk_idx;
  logic [c_TW-1:0] r_on_ticks, w_on_ticks;
  logic            r_play_done, w_play_done;
  logic            r_check_ok, w_check_ok;
  logic            r_check_fail, w_check_fail;
  logic            r_round_done, w_round_done;

  logic [1:0]      r_mem [MAX_ROUNDS];
  logic            w_mem_we;

  logic            w_cmd_clear, w_cmd_add, w_cmd_play, w_cmd_check;
  logic [c_TW-1:0] w_sel_ticks, w_play_reload, w_on_reload;
  logic            w_tmr_load, w_tmr_done;
  logic [c_TW-1:0] w_tmr_value;
  logic [1:0]      w_play_color, w_chk_color;

  // One command per cycle: lower-priority requests are dropped outright.
  assign w_cmd_clear = cmd_clear;
  assign w_cmd_add   = !cmd_clear && cmd_add;
  assign w_cmd_play  = !cmd_clear && !cmd_add && cmd_play;
  assign w_cmd_check = !cmd_clear && !cmd_add && !cmd_play && cmd_check;

  // Timer counts reload..0, so a phase lasts reload+1 cycles; clamp to 1 cycle.
  assign w_sel_ticks   = c_TW'(BASE_TICKS >> speed);
  assign w_play_reload = (w_sel_ticks == '0) ? '0 : w_sel_ticks - c_ONE;
  assign w_on_reload   = (r_on_ticks == '0) ? '0 : r_on_ticks - c_ONE;

  assign w_play_color = r_mem[r_play_idx[c_AW-1:0]];
  assign w_chk_color  = r_mem[r_chk_idx[c_AW-1:0]];

  tick_timer #(.WIDTH(c_TW)) u_tick_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (w_tmr_load),
    .load_value (w_tmr_value),
    .done       (w_tmr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_round      <= '0;
      r_play_idx   <= '0;
      r_chk_idx    <= '0;
      r_on_ticks   <= '0;
      r_play_done  <= 1'b0;
      r_check_ok   <= 1'b0;
      r_check_fail <= 1'b0;
      r_round_done <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_round      <= w_round;
      r_play_idx   <= w_play_idx;
      r_chk_idx    <= w_chk_idx;
      r_on_ticks   <= w_on_ticks;
      r_play_done  <= w_play_done;
      r_check_ok   <= w_check_ok;
      r_check_fail <= w_check_fail;
      r_round_done <= w_round_done;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_round      = r_round;
    w_play_idx   = r_play_idx;
    w_chk_idx    = r_chk_idx;
    w_on_ticks   = r_on_ticks;
    w_play_done  = 1'b0;
    w_check_ok   = 1'b0;
    w_check_fail = 1'b0;
    w_round_done = 1'b0;
    w_mem_we     = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_value  = w_on_reload;
    if (w_cmd_clear) begin
      w_state    = IDLE;
      w_round    = '0;
      w_play_idx = '0;
      w_chk_idx  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cmd_add) begin
            if (!seq_full) begin
              w_mem_we = 1'b1;
              w_round  = r_round + 6'd1;
            end
          end else if (w_cmd_play) begin
            w_on_ticks = w_sel_ticks;
            w_play_idx = '0;
            w_chk_idx  = '0;
            if (r_round == '0) begin
              w_play_done = 1'b1;
            end else begin
              w_state     = SHOW_ON;
              w_tmr_load  = 1'b1;
              w_tmr_value = w_play_reload;
            end
          end else if (w_cmd_check && (r_round != '0)) begin
            if (press_color == w_chk_color) begin
              w_check_ok = 1'b1;
              if (r_chk_idx == r_round - 6'd1) begin
                w_round_done = 1'b1;
                w_chk_idx    = '0;
              end else begin
                w_chk_idx = r_chk_idx + 6'd1;
              end
            end else begin
              w_check_fail = 1'b1;
              w_chk_idx    = '0;
            end
          end
        end
        SHOW_ON: begin
          if (w_tmr_done) begin
            w_state    = SHOW_OFF;
            w_tmr_load = 1'b1;
          end
        end
        SHOW_OFF: begin
          if (w_tmr_done) begin
            if (r_play_idx == r_round - 6'd1) begin
              w_state     = IDLE;
              w_play_done = 1'b1;
            end else begin
              w_play_idx = r_play_idx + 6'd1;
              w_state    = SHOW_ON;
              w_tmr_load = 1'b1;
            end
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end

  // Sequence storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_round[c_AW-1:0]] <= rng_color;
    end
  end

  assign led_on        = (r_state == SHOW_ON);
  assign led_color     = led_on ? w_play_color : 2'b00;
  assign play_busy     = (r_state != IDLE);
  assign play_done     = r_play_done;
  assign check_ok      = r_check_ok;
  assign check_fail    = r_check_fail;
  assign round_done    = r_round_done;
  assign current_round = r_round;
  assign seq_full      = (r_round == c_MAX);

endmodule
`default_nettype wire

// File: tb/tb_seq_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seq_engine : scoreboard bench for seq_engine (MAX_ROUNDS=4,      |
// |                 BASE_TICKS=8)                                      |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module tb_seq_engine;

  localparam int c_BASE = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_clear = 1'b0, cmd_add = 1'b0, cmd_play = 1'b0, cmd_check = 1'b0;
  logic [1:0] rng_color = '0, speed = '0, press_color = '0;
  logic       led_on, play_busy, play_done, check_ok, check_fail, round_done, seq_full;
  logic [1:0] led_color;
  logic [5:0] current_round;

  int n_checks = 0;
  int n_errors = 0;

  // {led_on, led_color, play_done, play_busy} per cycle after a play command
  logic [4:0] play_q [$];
  // {check_ok, check_fail, round_done} for the cycle after a check command
  logic [2:0] chk_q [$];

  seq_engine #(.MAX_ROUNDS(4), .BASE_TICKS(c_BASE)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_clear     (cmd_clear),
    .cmd_add       (cmd_add),
    .rng_color     (rng_color),
    .cmd_play      (cmd_play),
    .speed         (speed),
    .cmd_check     (cmd_check),
    .press_color   (press_color),
    .led_on        (led_on),
    .led_color     (led_color),
    .play_busy     (play_busy),
    .play_done     (play_done),
    .check_ok      (check_ok),
    .check_fail    (check_fail),
    .round_done    (round_done),
    .current_round (current_round),
    .seq_full      (seq_full)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    cmd_clear = 1'b1;
    tick();
    cmd_clear = 1'b0;
  endtask

  task automatic do_add(input logic [1:0] c);
    rng_color = c;
    cmd_add   = 1'b1;
    tick();
    cmd_add   = 1'b0;
  endtask

  // Expected playback: each entry on for `ticks`, off for `ticks`, then done pulse.
  task automatic push_play(input int n, input logic [7:0] colors, input int ticks);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < ticks; k++) play_q.push_back({1'b1, colors[2*i +: 2], 1'b0, 1'b1});
      for (int k = 0; k < ticks; k++) play_q.push_back({1'b0, 2'b00, 1'b0, 1'b1});
    end
    play_q.push_back({1'b0, 2'b00, 1'b1, 1'b0});
    play_q.push_back({1'b0, 2'b00, 1'b0, 1'b0});
  endtask

  task automatic run_play(input string name, input logic [1:0] spd);
    logic [4:0] exp_v;
    logic [4:0] got;
    int         cyc;
    speed    = spd;
    cmd_play = 1'b1;
    tick();
    cmd_play = 1'b0;
    cyc = 0;
    while (play_q.size() > 0) begin
      exp_v = play_q.pop_front();
      got   = {led_on, led_color, play_done, play_busy};
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL %s cycle %0d: got on/color/done/busy=%b required %b", name, cyc, got, exp_v);
      end
      cyc++;
      tick();
    end
  endtask

  task automatic do_check(input string name, input logic [1:0] c, input logic [2:0] exp_v);
    logic [2:0] e;
    chk_q.push_back(exp_v);
    press_color = c;
    cmd_check   = 1'b1;
    tick();
    cmd_check   = 1'b0;
    e = chk_q.pop_front();
    n_checks++;
    if ({check_ok, check_fail, round_done} !== e) begin
      n_errors++;
      $display("FAIL %s: got ok/fail/rdone=%b required %b", name, {check_ok, check_fail, round_done}, e);
    end
  endtask

  task automatic test_reset();
    logic [10:0] got;
    reset = 1'b1;
    tick();
    tick();
    got = {led_on, led_color, play_busy, play_done, check_ok, check_fail, round_done, seq_full, current_round == 6'd0};
    n_checks++;
    if (got !== 11'b000_0000_0001) begin
      n_errors++;
      $display("FAIL reset_state: got %b required 00000000001", got);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_play_speed0();
    do_clear();
    do_add(2'd2);
    do_add(2'd0);
    do_add(2'd3);
    n_checks++;
    if (current_round !== 6'd3) begin
      n_errors++;
      $display("FAIL round_after_adds: got %0d required 3", current_round);
    end
    push_play(3, 8'b00_11_00_10, c_BASE);
    run_play("play_speed0", 2'd0);
  endtask

  task automatic test_speed2_checks();
    do_clear();
    do_add(2'd1);
    do_add(2'd2);
    push_play(2, 8'b00_00_10_01, c_BASE >> 2);
    run_play("play_speed2", 2'd2);
    do_check("check_first", 2'd1, 3'b100);
    do_check("check_last", 2'd2, 3'b101);
    do_check("check_wrapped", 2'd1, 3'b100);
  endtask

  task automatic test_check_fail();
    do_clear();
    do_add(2'd1);
    do_add(2'd2);
    do_check("check_wrong", 2'd3, 3'b010);
    do_check("check_after_fail", 2'd1, 3'b100);
    do_clear();
    do_check("check_empty", 2'd0, 3'b000);
  endtask

  task automatic test_full();
    logic [7:0] got;
    do_clear();
    do_add(2'd0);
    do_add(2'd1);
    do_add(2'd2);
    do_add(2'd3);
    do_add(2'd1);
    n_checks++;
    if ({current_round, seq_full} !== {6'd4, 1'b1}) begin
      n_errors++;
      $display("FAIL seq_full: got round=%0d full=%b required round=4 full=1", current_round, seq_full);
    end
    push_play(4, 8'b11_10_01_00, c_BASE >> 3);
    run_play("play_full_speed3", 2'd3);
    do_clear();
    rng_color = 2'd2;
    cmd_add   = 1'b1;
    cmd_play  = 1'b1;
    tick();
    cmd_add   = 1'b0;
    cmd_play  = 1'b0;
    got = {current_round, play_busy, play_done};
    n_checks++;
    if (got !== {6'd1, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL add_play_priority: got round/busy/done=%b required %b", got, {6'd1, 2'b00});
    end
  endtask

  task automatic test_clear_mid_show();
    logic [8:0] got;
    logic       seen_done;
    do_clear();
    do_add(2'd3);
    do_add(2'd1);
    speed    = 2'd0;
    cmd_play = 1'b1;
    tick();
    cmd_play = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({led_on, led_color} !== 3'b111) begin
      n_errors++;
      $display("FAIL show_on_before_clear: got on/color=%b required 111", {led_on, led_color});
    end
    do_clear();
    got = {led_on, current_round, play_busy, play_done};
    n_checks++;
    if (got !== 9'd0) begin
      n_errors++;
      $display("FAIL clear_mid_show: got on/round/busy/done=%b required 0", got);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (play_done || led_on) seen_done = 1'b1;
      tick();
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_no_done: got activity=%b required 0", seen_done);
    end
    cmd_play = 1'b1;
    tick();
    cmd_play = 1'b0;
    n_checks++;
    if ({play_done, led_on, play_busy} !== 3'b100) begin
      n_errors++;
      $display("FAIL play_empty: got done/on/busy=%b required 100", {play_done, led_on, play_busy});
    end
    tick();
    n_checks++;
    if (play_done !== 1'b0) begin
      n_errors++;
      $display("FAIL play_empty_pulse: got done=%b required 0", play_done);
    end
  endtask

  task automatic test_reset_mid_off();
    logic [9:0] got;
    logic       seen_done;
    do_clear();
    do_add(2'd3);
    speed    = 2'd0;
    cmd_play = 1'b1;
    tick();
    cmd_play = 1'b0;
    do_check("check_during_play", 2'd3, 3'b000);
    for (int i = 0; i < 7; i++) tick();
    n_checks++;
    if ({led_on, play_busy} !== 2'b01) begin
      n_errors++;
      $display("FAIL in_show_off: got on/busy=%b required 01", {led_on, play_busy});
    end
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    got = {led_on, led_color, play_busy, play_done, check_ok, check_fail, round_done, seq_full, current_round != 6'd0};
    n_checks++;
    if (got !== 10'd0) begin
      n_errors++;
      $display("FAIL reset_mid_off: got %b required 0", got);
    end
    tick();
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (play_done || play_busy) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_no_done: got activity=%b required 0", seen_done);
    end
  endtask

  initial begin
    test_reset();
    test_play_speed0();
    test_speed2_checks();
    test_check_fail();
    test_full();
    test_clear_mid_show();
    test_reset_mid_off();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
